// File: rtl/vdma_axi_write_master.sv
// -----------------------------------------------------------------------------
// vdma_axi_write_master
//
// Last stage of the VDMA write path. Turns one burst request from the upstream
// scheduler into a single AXI4 write transaction (AW, W beats, B response).
// Burst data is pulled from the write-side data buffer through a read port
// with one cycle of latency. A 2-entry skid buffer hides that latency so the
// W channel can stream one beat per clock.
//
// Ports
//   ddr_clk_i, ddr_clk_rstn_i   clock, asynchronous active-low reset
//   write_req_i                 burst request level, held until write_ackn_o
//   write_length_i              AXI burst length (beats-1)
//   write_start_addr_i          burst byte address
//   write_ackn_o                1-cycle pulse after the AW handshake
//   write_done_o                1-cycle pulse after the B handshake
//   write_error_o               last BRESP was not OKAY; cleared on acceptance
//   buf_rd_o / buf_data_i       buffer read strobe, data one cycle later
//   aw*_o, awready_i            AXI write address channel
//   w*_o,  wready_i             AXI write data channel
//   bresp_i, bvalid_i, bready_o AXI write response channel
// -----------------------------------------------------------------------------
module vdma_axi_write_master #(
  parameter int          g_OP_DW   = 64,
  parameter int          g_AXI_IDW = 4,
  parameter int unsigned g_AXI_ID  = 0
) (
  input  logic                   ddr_clk_i,
  input  logic                   ddr_clk_rstn_i,
  input  logic                   write_req_i,
  input  logic [7:0]             write_length_i,
  input  logic [37:0]            write_start_addr_i,
  output logic                   write_ackn_o,
  output logic                   write_done_o,
  output logic                   write_error_o,
  output logic                   buf_rd_o,
  input  logic [g_OP_DW-1:0]     buf_data_i,
  output logic [g_AXI_IDW-1:0]   awid_o,
  output logic [37:0]            awaddr_o,
  output logic [7:0]             awlen_o,
  output logic [2:0]             awsize_o,
  output logic [1:0]             awburst_o,
  output logic                   awvalid_o,
  input  logic                   awready_i,
  output logic [g_OP_DW-1:0]     wdata_o,
  output logic [g_OP_DW/8-1:0]   wstrb_o,
  output logic                   wlast_o,
  output logic                   wvalid_o,
  input  logic                   wready_i,
  input  logic [1:0]             bresp_i,
  input  logic                   bvalid_i,
  output logic                   bready_o
);

  localparam logic [2:0] c_AWSIZE = 3'($clog2(g_OP_DW / 8));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  state_t state_reg, state_next;

  // Holds off request acceptance in the first cycle after reset so that the
  // combinational buffer read strobe can never fire while reset is asserted.
  logic               armed_reg;
  logic [37:0]        addr_reg;
  logic [7:0]         len_reg;
  logic               awvalid_reg;
  logic               ackn_reg;
  logic               done_reg;
  logic               error_reg;
  logic [8:0]         rd_count_reg;     // buffer reads issued this burst
  logic [8:0]         beat_count_reg;   // W beats accepted this burst
  logic               rd_pending_reg;   // a read was issued last cycle
  logic [g_OP_DW-1:0] skid_mem_reg [2];
  logic               skid_wr_ptr_reg;
  logic               skid_rd_ptr_reg;
  logic [1:0]         skid_count_reg;

  logic accept;
  logic aw_fire;
  logic w_valid;
  logic w_last;
  logic w_fire;
  logic w_all_sent;
  logic rd_burst;
  logic b_fire;

  assign accept  = (state_reg == ST_IDLE) && armed_reg && write_req_i;
  assign aw_fire = awvalid_reg && awready_i;
  assign w_valid = (skid_count_reg != 2'd0);
  assign w_last  = w_valid && (beat_count_reg == {1'b0, len_reg});
  assign w_fire  = w_valid && wready_i;
  assign b_fire  = (state_reg == ST_RESP) && bvalid_i;

  // True once every beat has been accepted, including one accepted this cycle.
  // Lets the FSM skip DATA when the W burst finishes ahead of the AW handshake.
  assign w_all_sent = (beat_count_reg == ({1'b0, len_reg} + 9'd1)) || (w_fire && w_last);

  // A new read is allowed only if its data is guaranteed a free skid slot when
  // it lands: entries held plus the read in flight, minus the beat leaving now,
  // must leave at least one slot. Steady state with wready high sits at exactly
  // one held entry plus one in flight, which sustains a beat every cycle.
  assign rd_burst = ((state_reg == ST_ADDR) || (state_reg == ST_DATA)) &&
                    (rd_count_reg <= {1'b0, len_reg}) &&
                    (({1'b0, skid_count_reg} + {2'b00, rd_pending_reg}) <=
                     (3'd1 + {2'b00, w_fire}));

  // The first read is a prefetch issued in the accepting cycle.
  assign buf_rd_o = accept | rd_burst;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge ddr_clk_i or negedge ddr_clk_rstn_i) begin
    if (!ddr_clk_rstn_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (aw_fire) begin
          state_next = w_all_sent ? ST_RESP : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_fire && w_last) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bvalid_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch, AW channel, counters and handshake pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge ddr_clk_i or negedge ddr_clk_rstn_i) begin
    if (!ddr_clk_rstn_i) begin
      armed_reg      <= 1'b0;
      addr_reg       <= '0;
      len_reg        <= '0;
      awvalid_reg    <= 1'b0;
      ackn_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      rd_count_reg   <= '0;
      beat_count_reg <= '0;
      rd_pending_reg <= 1'b0;
    end else begin
      armed_reg      <= 1'b1;
      ackn_reg       <= aw_fire;
      done_reg       <= b_fire;
      rd_pending_reg <= buf_rd_o;

      if (accept) begin
        addr_reg       <= write_start_addr_i;
        len_reg        <= write_length_i;
        error_reg      <= 1'b0;
        awvalid_reg    <= 1'b1;
        rd_count_reg   <= 9'd1;
        beat_count_reg <= '0;
      end else begin
        if (aw_fire) begin
          awvalid_reg <= 1'b0;
        end
        if (rd_burst) begin
          rd_count_reg <= rd_count_reg + 9'd1;
        end
        if (w_fire) begin
          beat_count_reg <= beat_count_reg + 9'd1;
        end
      end

      if (b_fire) begin
        error_reg <= (bresp_i != 2'b00);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer: 2-entry circular FIFO between buffer read port and W channel
  // ---------------------------------------------------------------------------
  always_ff @(posedge ddr_clk_i or negedge ddr_clk_rstn_i) begin
    if (!ddr_clk_rstn_i) begin
      skid_mem_reg[0] <= '0;
      skid_mem_reg[1] <= '0;
      skid_wr_ptr_reg <= 1'b0;
      skid_rd_ptr_reg <= 1'b0;
      skid_count_reg  <= '0;
    end else begin
      if (rd_pending_reg) begin
        skid_mem_reg[skid_wr_ptr_reg] <= buf_data_i;
        skid_wr_ptr_reg               <= ~skid_wr_ptr_reg;
      end
      if (w_fire) begin
        skid_rd_ptr_reg <= ~skid_rd_ptr_reg;
      end
      skid_count_reg <= 2'(skid_count_reg + {1'b0, rd_pending_reg} - {1'b0, w_fire});
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign awid_o        = g_AXI_IDW'(g_AXI_ID);
  assign awaddr_o      = addr_reg;
  assign awlen_o       = len_reg;
  assign awsize_o      = c_AWSIZE;
  assign awburst_o     = 2'b01;
  assign awvalid_o     = awvalid_reg;
  assign wdata_o       = skid_mem_reg[skid_rd_ptr_reg];
  assign wstrb_o       = '1;
  assign wlast_o       = w_last;
  assign wvalid_o      = w_valid;
  assign bready_o      = (state_reg == ST_RESP);
  assign write_ackn_o  = ackn_reg;
  assign write_done_o  = done_reg;
  assign write_error_o = error_reg;

endmodule
